// File: rtl/req_rr_arbiter_pkg.sv
// Shared definitions for the round-robin request arbiter.
//   NDefault    : default number of request lines (encoder pairing needs 4)
//   arb_state_e : two-state handshake FSM encoding
//   ptr_width() : width of the round-robin pointer for a given line count
package req_rr_arbiter_pkg;

   localparam int unsigned NDefault = 4;

   typedef enum logic {
      StIdle  = 1'b0,
      StOffer = 1'b1
   } arb_state_e;

   // Pointer width is log2(n); clamp to 1 so a degenerate n never yields a zero-width vector.
   function automatic int unsigned ptr_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/req_rr_arbiter_if.sv
// Request/grant bundle between requesters, the arbiter and the downstream encoder stage.
//   req     : request levels, synchronous to clk (driven by master)
//   ovf_clr : clear all sticky overflow flags (driven by master)
//   ready   : consumer accepts current grant (driven by master)
//   grant   : registered one-hot grant, zero when valid=0 (driven by slave)
//   valid   : grant holds a request (driven by slave)
//   pending : captured, not-yet-granted events (driven by slave)
//   ovf     : sticky per-line lost-event flags (driven by slave)
interface req_rr_arbiter_if #(
   parameter int unsigned N = req_rr_arbiter_pkg::NDefault
);
   logic [N-1:0] req;
   logic         ovf_clr;
   logic         ready;
   logic [N-1:0] grant;
   logic         valid;
   logic [N-1:0] pending;
   logic [N-1:0] ovf;

   modport master (
      output req, ovf_clr, ready,
      input  grant, valid, pending, ovf
   );

   modport slave (
      input  req, ovf_clr, ready,
      output grant, valid, pending, ovf
   );
endinterface

// File: rtl/req_rr_arbiter_rr_pick.sv
// Combinational round-robin selector.
//   pending_i : candidate lines
//   ptr_i     : highest-priority line; search runs ptr, ptr+1, ... wrapping mod N
//   pick_o    : one-hot selected line, zero when nothing is pending
//   any_o     : at least one line is pending
module req_rr_arbiter_rr_pick
   import req_rr_arbiter_pkg::*;
#(
   parameter int unsigned N    = NDefault,
   parameter int unsigned PtrW = ptr_width(N)
) (
   input  logic [N-1:0]    pending_i,
   input  logic [PtrW-1:0] ptr_i,
   output logic [N-1:0]    pick_o,
   output logic            any_o
);

   logic [PtrW-1:0] idx;
   logic            found;

   always_comb begin
      pick_o = '0;
      found  = 1'b0;
      idx    = '0;
      for (int unsigned k = 0; k < N; k++) begin
         // N is a power of two, so natural truncation of the sum is the modulo wrap.
         idx = ptr_i + PtrW'(k);
         if (!found && pending_i[idx]) begin
            pick_o[idx] = 1'b1;
            found       = 1'b1;
         end
      end
   end

   assign any_o = |pending_i;

endmodule

// File: rtl/req_rr_arbiter.sv
// Edge-capturing round-robin arbiter with a registered one-hot valid/ready grant.
//   clk_i : rising-edge clock
//   rst_i : synchronous active-high reset
//   bus   : slave side of req_rr_arbiter_if (req/ovf_clr/ready in, grant/valid/pending/ovf out)
// Every output comes straight from a register; ready and req only reach next-state logic.
module req_rr_arbiter
   import req_rr_arbiter_pkg::*;
#(
   parameter int unsigned N = NDefault
) (
   input  logic                clk_i,
   input  logic                rst_i,
   req_rr_arbiter_if.slave     bus
);

   localparam int unsigned PtrW = ptr_width(N);

   arb_state_e      state_q, state_d;
   logic [N-1:0]    req_q;
   logic [N-1:0]    pending_q, pending_d;
   logic [N-1:0]    ovf_q, ovf_d;
   logic [N-1:0]    grant_q, grant_d;
   logic [PtrW-1:0] ptr_q, ptr_d;

   logic [N-1:0]    req_edge;
   logic [N-1:0]    pick;
   logic            any;
   logic            load;
   logic [N-1:0]    clr;

   // Only the registered pending vector is searched, so this cycle's edges wait a cycle.
   req_rr_arbiter_rr_pick #(
      .N    (N),
      .PtrW (PtrW)
   ) u_pick (
      .pending_i (pending_q),
      .ptr_i     (ptr_q),
      .pick_o    (pick),
      .any_o     (any)
   );

   assign req_edge = bus.req & ~req_q;
   assign clr      = load ? pick : '0;

   // Set beats clear on the same line; overflow only when the line stays pending.
   assign pending_d = (pending_q & ~clr) | req_edge;
   assign ovf_d     = (bus.ovf_clr ? '0 : ovf_q) | (req_edge & pending_q & ~clr);

   // State register and all other state.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         req_q     <= '0;
         pending_q <= '0;
         ovf_q     <= '0;
         grant_q   <= '0;
         ptr_q     <= '0;
      end else begin
         state_q   <= state_d;
         req_q     <= bus.req;
         pending_q <= pending_d;
         ovf_q     <= ovf_d;
         grant_q   <= grant_d;
         ptr_q     <= ptr_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (any) state_d = StOffer;
         StOffer: if (bus.ready && !any) state_d = StIdle;
      endcase
   end

   // Grant loading and pointer update; grant is held while offered and not accepted.
   always_comb begin
      load    = 1'b0;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         StIdle: begin
            if (any) begin
               load    = 1'b1;
               grant_d = pick;
            end
         end
         StOffer: begin
            if (bus.ready) begin
               if (any) begin
                  load    = 1'b1;
                  grant_d = pick;
               end else begin
                  grant_d = '0;
               end
            end
         end
      endcase
      if (load) begin
         for (int unsigned i = 0; i < N; i++) begin
            if (pick[i]) ptr_d = PtrW'(i + 1);
         end
      end
   end

   assign bus.grant   = grant_q;
   assign bus.valid   = (state_q == StOffer);
   assign bus.pending = pending_q;
   assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_req_rr_arbiter.sv
module tb_req_rr_arbiter;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst;

   req_rr_arbiter_if #(.N(N)) bus ();

   req_rr_arbiter #(.N(N)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: per-line pending/ovf flags, integer pointer, index of the offered line.
   bit       m_pend[N];
   bit       m_ovf[N];
   bit [3:0] m_req_prev;
   int       m_ptr;
   bit       m_valid;
   int       m_gidx;

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_pend[i] = 1'b0;
         m_ovf[i]  = 1'b0;
      end
      m_req_prev = '0;
      m_ptr      = 0;
      m_valid    = 1'b0;
      m_gidx     = -1;
   endtask

   task automatic model_clock(input bit [3:0] req, input bit clr, input bit rdy, input bit r);
      int  pick;
      bit  edges[N];
      if (r) begin
         model_reset();
         return;
      end
      for (int i = 0; i < N; i++) edges[i] = req[i] && !m_req_prev[i];
      pick = -1;
      if (!m_valid || rdy) begin
         for (int k = 0; k < N; k++) begin
            if (pick < 0 && m_pend[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
         end
         if (pick >= 0) begin
            m_valid = 1'b1;
            m_gidx  = pick;
            m_ptr   = (pick + 1) % N;
         end else if (m_valid) begin
            m_valid = 1'b0;
            m_gidx  = -1;
         end
      end
      if (clr) for (int i = 0; i < N; i++) m_ovf[i] = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (edges[i]) begin
            if (m_pend[i] && i != pick) m_ovf[i] = 1'b1;
            m_pend[i] = 1'b1;
         end else if (i == pick) begin
            m_pend[i] = 1'b0;
         end
      end
      m_req_prev = req;
   endtask

   function automatic logic [3:0] m_grant_vec();
      logic [3:0] v;
      v = '0;
      if (m_valid) v[m_gidx] = 1'b1;
      return v;
   endfunction

   function automatic logic [3:0] m_vec(input bit a[N]);
      logic [3:0] v;
      for (int i = 0; i < N; i++) v[i] = a[i];
      return v;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, ".grant"},   {28'b0, bus.grant},   {28'b0, m_grant_vec()});
      check({tag, ".valid"},   {31'b0, bus.valid},   {31'b0, m_valid});
      check({tag, ".pending"}, {28'b0, bus.pending}, {28'b0, m_vec(m_pend)});
      check({tag, ".ovf"},     {28'b0, bus.ovf},     {28'b0, m_vec(m_ovf)});
   endtask

   // One clock: drive inputs away from the edge, advance the model, sample 1 time unit after.
   task automatic step(input logic [3:0] req, input logic clr, input logic rdy, input logic r,
                       input string tag);
      bus.req     = req;
      bus.ovf_clr = clr;
      bus.ready   = rdy;
      rst         = r;
      model_clock(req, clr, rdy, r);
      @(posedge clk);
      #1;
      check_model(tag);
   endtask

   initial begin
      bus.req     = '0;
      bus.ovf_clr = 1'b0;
      bus.ready   = 1'b0;
      rst         = 1'b1;
      model_reset();
      #1;

      // Reset.
      step(4'b0000, 1'b0, 1'b0, 1'b1, "rst0");
      step(4'b0000, 1'b0, 1'b0, 1'b1, "rst1");
      check("rst.grant", {28'b0, bus.grant}, 32'h0);
      check("rst.valid", {31'b0, bus.valid}, 32'h0);

      // Simultaneous requests with ptr=0: 0001 then 0100 back to back.
      step(4'b0101, 1'b0, 1'b1, 1'b0, "sim0");
      check("sim.pend", {28'b0, bus.pending}, 32'h5);
      step(4'b0101, 1'b0, 1'b1, 1'b0, "sim1");
      check("sim.g0", {28'b0, bus.grant}, 32'h1);
      step(4'b0000, 1'b0, 1'b1, 1'b0, "sim2");
      check("sim.g1", {28'b0, bus.grant}, 32'h4);
      step(4'b0000, 1'b0, 1'b1, 1'b0, "sim3");
      check("sim.idle", {31'b0, bus.valid}, 32'h0);

      // Single event with two-cycle latency.
      step(4'b0100, 1'b0, 1'b1, 1'b0, "one0");
      check("one.pend", {28'b0, bus.pending}, 32'h4);
      check("one.nv", {31'b0, bus.valid}, 32'h0);
      step(4'b0100, 1'b0, 1'b1, 1'b0, "one1");
      check("one.grant", {28'b0, bus.grant}, 32'h4);
      step(4'b0100, 1'b0, 1'b1, 1'b0, "one2");
      check("one.done", {31'b0, bus.valid}, 32'h0);
      step(4'b0000, 1'b0, 1'b1, 1'b0, "one3");

      // Backpressure: grant 0010 held for 5 cycles of ready=0.
      step(4'b0010, 1'b0, 1'b0, 1'b0, "bp0");
      step(4'b0000, 1'b0, 1'b0, 1'b0, "bp1");
      for (int i = 0; i < 5; i++) begin
         step(4'b0000, 1'b0, 1'b0, 1'b0, "bpw");
         check("bp.grant", {28'b0, bus.grant}, 32'h2);
      end
      step(4'b0000, 1'b0, 1'b1, 1'b0, "bpacc");
      check("bp.acc", {31'b0, bus.valid}, 32'h0);

      // Fairness: all four lines pulsing, ready high.
      for (int i = 0; i < 12; i++) step((i % 2 == 0) ? 4'b1111 : 4'b0000, 1'b0, 1'b1, 1'b0, "fair");
      for (int i = 0; i < 6; i++) step(4'b0000, 1'b0, 1'b1, 1'b0, "fdrain");
      step(4'b0000, 1'b1, 1'b1, 1'b0, "fclr");

      // Overflow: bit1 pulses twice while pending and stalled.
      step(4'b0001, 1'b0, 1'b0, 1'b0, "ov0");
      step(4'b0000, 1'b0, 1'b0, 1'b0, "ov1");
      step(4'b0010, 1'b0, 1'b0, 1'b0, "ov2");
      step(4'b0000, 1'b0, 1'b0, 1'b0, "ov3");
      step(4'b0010, 1'b0, 1'b0, 1'b0, "ov4");
      check("ov.set", {28'b0, bus.ovf}, 32'h2);
      step(4'b0000, 1'b1, 1'b0, 1'b0, "ov5");
      check("ov.clr", {28'b0, bus.ovf}, 32'h0);

      // Set-wins: bit2 re-pulses on the edge it gets granted.
      step(4'b0000, 1'b0, 1'b1, 1'b0, "sw0");
      step(4'b0100, 1'b0, 1'b0, 1'b0, "sw1");
      step(4'b0000, 1'b0, 1'b0, 1'b0, "sw2");
      step(4'b0100, 1'b0, 1'b1, 1'b0, "sw3");
      check("sw.grant", {28'b0, bus.grant}, 32'h4);
      check("sw.pend2", {31'b0, bus.pending[2]}, 32'h1);
      check("sw.ovf", {28'b0, bus.ovf}, 32'h0);
      step(4'b0000, 1'b0, 1'b1, 1'b0, "sw4");
      step(4'b0000, 1'b0, 1'b1, 1'b0, "sw5");

      // Reset mid-OFFER with pending 1010; bit3 held through reset.
      step(4'b0001, 1'b0, 1'b0, 1'b0, "rm0");
      step(4'b0000, 1'b0, 1'b0, 1'b0, "rm1");
      step(4'b1010, 1'b0, 1'b0, 1'b0, "rm2");
      check("rm.pend", {28'b0, bus.pending}, 32'ha);
      step(4'b1000, 1'b0, 1'b0, 1'b1, "rm3");
      check("rm.valid", {31'b0, bus.valid}, 32'h0);
      check("rm.pend0", {28'b0, bus.pending}, 32'h0);
      step(4'b1000, 1'b0, 1'b1, 1'b0, "rm4");
      check("rm.nv", {31'b0, bus.valid}, 32'h0);
      step(4'b1000, 1'b0, 1'b1, 1'b0, "rm5");
      check("rm.fresh", {28'b0, bus.grant}, 32'h8);

      // Randomized traffic against the model.
      for (int i = 0; i < 800; i++) begin
         step(4'($urandom), ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7),
              ($urandom_range(0, 99) == 0), "rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
